fpnew_inorder_rob: RTL and testbench

- Sits directly downstream of the FPNew wrapper, and also controls its input handshake; operand/op fields go straight from the issuer to the FPU.
- Allocates an FPU tag per accepted request and captures results that return out of order, since FPU units differ in latency.
- Releases results to writeback strictly in issue order, carrying a user sideband per request.
- Also handles flush and busy tracking for the FPU pair.

---
 rtl/fpnew_rob_pkg.sv | 22 ++
 rtl/fpnew_rob_slot.sv | 59 +++++
 rtl/fpnew_inorder_rob.sv | 117 +++++++++++
 tb/tb_fpnew_inorder_rob.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_rob_pkg.sv
// Shared types for the FPU in-order reorder buffer: slot state encoding
// and the FPU status flag layout.
package fpnew_rob_pkg;

  localparam int STATUS_W = 5;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    DONE    = 2'd2
  } slot_state_e;

  // Same bit order as the FPU status field: {NV,DZ,OF,UF,NX}
  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_status_t;

endpackage

// File: rtl/fpnew_rob_slot.sv
// One reorder slot: lifecycle state plus the captured user sideband,
// FPU result and status. Strobes come pre-decoded from the top.
module fpnew_rob_slot
  import fpnew_rob_pkg::*;
#(
  parameter int FLEN   = 64,
  parameter int USER_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_i,
  input  logic              complete_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [USER_W-1:0] user_i,
  input  logic [FLEN-1:0]   result_i,
  input  fpu_status_t       status_i,
  output slot_state_e       state_o,
  output logic [USER_W-1:0] user_o,
  output logic [FLEN-1:0]   result_o,
  output fpu_status_t       status_o
);

  slot_state_e       state_q;
  logic [USER_W-1:0] user_q;
  logic [FLEN-1:0]   result_q;
  fpu_status_t       status_q;

  // Slot lifecycle; flush kills the slot regardless of where it is
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= FREE;
    end else if (flush_i) begin
      state_q <= FREE;
    end else begin
      case (state_q)
        FREE:    if (alloc_i)    state_q <= PENDING;
        PENDING: if (complete_i) state_q <= DONE;
        DONE:    if (pop_i)      state_q <= FREE;
        default:                 state_q <= FREE;
      endcase
    end
  end

  // Payload capture; contents are only meaningful while the state says so
  always_ff @(posedge clk_i) begin
    if (alloc_i && !flush_i && state_q == FREE) user_q <= user_i;
    if (complete_i && !flush_i && state_q == PENDING) begin
      result_q <= result_i;
      status_q <= status_i;
    end
  end

  assign state_o  = state_q;
  assign user_o   = user_q;
  assign result_o = result_q;
  assign status_o = status_q;

endmodule

// File: rtl/fpnew_inorder_rob.sv
// In-order reorder buffer behind the FPNew wrapper. Hands out the tail
// index as FPU tag, catches out-of-order completions by tag, and releases
// results to writeback strictly in issue order.
module fpnew_inorder_rob
  import fpnew_rob_pkg::*;
#(
  parameter int FLEN   = 64,
  parameter int DEPTH  = 4,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int USER_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [USER_W-1:0]   req_user_i,
  output logic                fpu_in_valid_o,
  input  logic                fpu_in_ready_i,
  output logic [IDX_W-1:0]    fpu_tag_o,
  output logic                fpu_flush_o,
  input  logic                fpu_out_valid_i,
  output logic                fpu_out_ready_o,
  input  logic [IDX_W-1:0]    fpu_tag_i,
  input  logic [FLEN-1:0]     fpu_result_i,
  input  logic [STATUS_W-1:0] fpu_status_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [FLEN-1:0]     rsp_result_o,
  output logic [STATUS_W-1:0] rsp_status_o,
  output logic [USER_W-1:0]   rsp_user_o,
  input  logic                flush_i,
  output logic                busy_o,
  output logic [IDX_W:0]      count_o,
  output logic                err_o
);

  logic [IDX_W:0]   head_q, tail_q;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             full, empty;
  logic             alloc_go, pop_go, cpl_hit, cpl_bad;
  logic             err_q;

  slot_state_e                  slot_state [DEPTH];
  logic [DEPTH-1:0][USER_W-1:0] slot_user;
  logic [DEPTH-1:0][FLEN-1:0]   slot_result;
  fpu_status_t [DEPTH-1:0]      slot_status;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty    = (head_q == tail_q);

  // Issue side: the FPU sees the request only when a slot is free for it
  assign fpu_in_valid_o = req_valid_i & ~full & ~flush_i;
  assign req_ready_o    = fpu_in_ready_i & ~full & ~flush_i;
  assign fpu_tag_o      = tail_idx;
  assign fpu_flush_o    = flush_i;
  assign alloc_go       = req_valid_i & req_ready_o;

  // Every in-flight op owns a slot, so completions never need to stall
  assign fpu_out_ready_o = 1'b1;
  assign cpl_hit = fpu_out_valid_i & ~flush_i & (slot_state[fpu_tag_i] == PENDING);
  assign cpl_bad = fpu_out_valid_i & ~flush_i & (slot_state[fpu_tag_i] != PENDING);

  // Release side reads straight from the head slot's registers
  assign rsp_valid_o  = (slot_state[head_idx] == DONE);
  assign rsp_user_o   = slot_user[head_idx];
  assign rsp_result_o = slot_result[head_idx];
  assign rsp_status_o = slot_status[head_idx];
  assign pop_go       = rsp_valid_o & rsp_ready_i & ~flush_i;

  assign busy_o  = ~empty;
  assign count_o = tail_q - head_q;
  assign err_o   = err_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    fpnew_rob_slot #(
      .FLEN   (FLEN),
      .USER_W (USER_W)
    ) u_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .alloc_i    (alloc_go && (tail_idx == IDX_W'(i))),
      .complete_i (cpl_hit && (fpu_tag_i == IDX_W'(i))),
      .pop_i      (pop_go && (head_idx == IDX_W'(i))),
      .flush_i    (flush_i),
      .user_i     (req_user_i),
      .result_i   (fpu_result_i),
      .status_i   (fpu_status_t'(fpu_status_i)),
      .state_o    (slot_state[i]),
      .user_o     (slot_user[i]),
      .result_o   (slot_result[i]),
      .status_o   (slot_status[i])
    );
  end

  // Head/tail pointers with wrap bit; flush rewinds both to zero
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (alloc_go) tail_q <= tail_q + 1'b1;
      if (pop_go)   head_q <= head_q + 1'b1;
    end
  end

  // Sticky error for results aimed at a slot that was not waiting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        err_q <= 1'b0;
    else if (cpl_bad) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_fpnew_inorder_rob.sv
// Bench for fpnew_inorder_rob: directed scenarios plus a randomized run,
// all checked against an issue-order queue model of outstanding ops.
module tb_fpnew_inorder_rob;
  localparam int FLEN = 64, DEPTH = 4, IDX_W = 2, USER_W = 8;

  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, fpu_in_valid, fpu_in_ready = 0;
  logic [USER_W-1:0] req_user = '0, rsp_user;
  logic [IDX_W-1:0]  fpu_tag_o, fpu_tag_in = '0;
  logic fpu_flush, fpu_out_valid = 0, fpu_out_ready;
  logic [FLEN-1:0] fpu_result = '0, rsp_result;
  logic [4:0] fpu_status = '0, rsp_status;
  logic rsp_valid, rsp_ready = 0, flush = 0, busy, err;
  logic [IDX_W:0] count;

  int checks = 0, errors = 0;

  typedef struct {
    logic [USER_W-1:0] user;
    int                tag;
    bit                done;
    logic [FLEN-1:0]   res;
    logic [4:0]        st;
  } ent_t;
  ent_t q[$];
  int   next_tag = 0;
  bit   err_m = 0;

  fpnew_inorder_rob #(.FLEN(FLEN), .DEPTH(DEPTH), .USER_W(USER_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_user_i(req_user),
    .fpu_in_valid_o(fpu_in_valid), .fpu_in_ready_i(fpu_in_ready),
    .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush),
    .fpu_out_valid_i(fpu_out_valid), .fpu_out_ready_o(fpu_out_ready),
    .fpu_tag_i(fpu_tag_in), .fpu_result_i(fpu_result), .fpu_status_i(fpu_status),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_status_o(rsp_status), .rsp_user_o(rsp_user),
    .flush_i(flush), .busy_o(busy), .count_o(count), .err_o(err)
  );

  always #5 clk = ~clk;

  // Advance one clock, applying the current inputs to the model first
  task automatic step();
    bit full_m = (q.size() == DEPTH);
    bit pop_m;
    int k;
    if (rst) begin
      q.delete(); next_tag = 0; err_m = 0;
    end else if (flush) begin
      q.delete(); next_tag = 0;
    end else begin
      pop_m = (q.size() > 0) && q[0].done && rsp_ready;
      if (fpu_out_valid) begin
        k = -1;
        foreach (q[j]) if (q[j].tag == int'(fpu_tag_in) && !q[j].done) k = j;
        if (k < 0) err_m = 1;
        else begin q[k].done = 1; q[k].res = fpu_result; q[k].st = fpu_status; end
      end
      if (req_valid && fpu_in_ready && !full_m) begin
        q.push_back('{user: req_user, tag: next_tag, done: 0, res: '0, st: '0});
        next_tag = (next_tag + 1) % DEPTH;
      end
      if (pop_m) void'(q.pop_front());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_flush();
    flush = 1; step(); flush = 0;
  endtask

  task automatic issue(input logic [USER_W-1:0] u);
    req_valid = 1; req_user = u; fpu_in_ready = 1; step(); req_valid = 0;
  endtask

  task automatic ret(input logic [IDX_W-1:0] t, input logic [FLEN-1:0] r, input logic [4:0] s);
    fpu_out_valid = 1; fpu_tag_in = t; fpu_result = r; fpu_status = s; step(); fpu_out_valid = 0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (req_ready !== 1'b0 || fpu_in_valid !== 1'b0)
      begin errors++; $display("FAIL reset_hs got rdy=%b ivld=%b want 0 0", req_ready, fpu_in_valid); end
    @(negedge clk); rst = 0; @(posedge clk); #1;
  endtask

  task automatic test_inorder_single();
    do_flush();
    req_valid = 1; req_user = 8'h11; fpu_in_ready = 1; #1;
    checks++; if (fpu_tag_o !== 2'd0 || req_ready !== 1'b1)
      begin errors++; $display("FAIL single_issue got tag=%0d rdy=%b want 0 1", fpu_tag_o, req_ready); end
    step(); req_valid = 0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", count); end
    step();
    fpu_out_valid = 1; fpu_tag_in = 0; fpu_result = 64'h3FF0000000000000; fpu_status = 0; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_nobypass got %b want 0", rsp_valid); end
    step(); fpu_out_valid = 0;
    checks++; if (rsp_valid !== 1'b1 || rsp_user !== 8'h11 || rsp_result !== 64'h3FF0000000000000)
      begin errors++; $display("FAIL single_rsp got v=%b u=%h r=%h want 1 11 3ff0000000000000", rsp_valid, rsp_user, rsp_result); end
    rsp_ready = 1; step(); rsp_ready = 0;
    checks++; if (count !== 3'd0 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL single_pop got cnt=%0d v=%b want 0 0", count, rsp_valid); end
  endtask

  task automatic test_out_of_order();
    do_flush();
    issue(8'hA1); issue(8'hB2);
    ret(2'd1, 64'hBBBB, 5'h01);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ooo_wait got %b want 0", rsp_valid); end
    ret(2'd0, 64'hAAAA, 5'h10);
    checks++; if (rsp_valid !== 1'b1 || rsp_user !== 8'hA1 || rsp_result !== 64'hAAAA || rsp_status !== 5'h10)
      begin errors++; $display("FAIL ooo_first got v=%b u=%h r=%h s=%h want 1 a1 aaaa 10", rsp_valid, rsp_user, rsp_result, rsp_status); end
    rsp_ready = 1; step();
    checks++; if (rsp_valid !== 1'b1 || rsp_user !== 8'hB2 || rsp_result !== 64'hBBBB)
      begin errors++; $display("FAIL ooo_second got v=%b u=%h r=%h want 1 b2 bbbb", rsp_valid, rsp_user, rsp_result); end
    step(); rsp_ready = 0;
    checks++; if (rsp_valid !== 1'b0 || count !== 3'd0)
      begin errors++; $display("FAIL ooo_drain got v=%b cnt=%0d want 0 0", rsp_valid, count); end
  endtask

  task automatic test_full();
    do_flush();
    for (int i = 0; i < 4; i++) issue(8'h20 + 8'(i));
    req_valid = 1; req_user = 8'h55; #1;
    checks++; if (count !== 3'd4 || busy !== 1'b1)
      begin errors++; $display("FAIL full_count got cnt=%0d busy=%b want 4 1", count, busy); end
    checks++; if (req_ready !== 1'b0 || fpu_in_valid !== 1'b0)
      begin errors++; $display("FAIL full_block got rdy=%b ivld=%b want 0 0", req_ready, fpu_in_valid); end
    ret(2'd0, 64'h1, 5'h0);
    rsp_ready = 1; #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL full_pop_same got rdy=%b want 0", req_ready); end
    step(); rsp_ready = 0;
    checks++; if (count !== 3'd3 || req_ready !== 1'b1 || fpu_tag_o !== 2'd0)
      begin errors++; $display("FAIL full_reopen got cnt=%0d rdy=%b tag=%0d want 3 1 0", count, req_ready, fpu_tag_o); end
    step(); req_valid = 0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_refill got %0d want 4", count); end
  endtask

  task automatic test_backpressure();
    do_flush();
    for (int i = 0; i < 3; i++) issue(8'h31 + 8'(i));
    ret(2'd0, 64'hC0, 5'h0);
    for (int c = 0; c < 5; c++) begin
      fpu_out_valid = (c < 2); fpu_tag_in = 2'(c + 1); fpu_result = 64'hC1 + 64'(c); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_user !== 8'h31 || rsp_result !== 64'hC0)
        begin errors++; $display("FAIL bp_hold c=%0d got v=%b u=%h r=%h want 1 31 c0", c, rsp_valid, rsp_user, rsp_result); end
      step();
    end
    fpu_out_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_user !== 8'h31 + 8'(i) || rsp_result !== 64'hC0 + 64'(i))
        begin errors++; $display("FAIL bp_drain i=%0d got v=%b u=%h r=%h", i, rsp_valid, rsp_user, rsp_result); end
      step();
    end
    rsp_ready = 0;
    checks++; if (count !== 3'd0 || busy !== 1'b0)
      begin errors++; $display("FAIL bp_empty got cnt=%0d busy=%b want 0 0", count, busy); end
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 3; i++) issue(8'h41 + 8'(i));
    fpu_out_valid = 1; fpu_tag_in = 0; fpu_result = 64'hDEAD; req_valid = 1; req_user = 8'h99; flush = 1; #1;
    checks++; if (fpu_flush !== 1'b1 || req_ready !== 1'b0 || fpu_in_valid !== 1'b0)
      begin errors++; $display("FAIL flush_cycle got fl=%b rdy=%b ivld=%b want 1 0 0", fpu_flush, req_ready, fpu_in_valid); end
    step(); flush = 0; fpu_out_valid = 0; req_valid = 0;
    checks++; if (count !== 3'd0 || busy !== 1'b0 || err !== 1'b0 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL flush_after got cnt=%0d busy=%b err=%b v=%b want 0 0 0 0", count, busy, err, rsp_valid); end
    req_valid = 1; #1;
    checks++; if (fpu_tag_o !== 2'd0) begin errors++; $display("FAIL flush_tag got %0d want 0", fpu_tag_o); end
    step(); req_valid = 0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL flush_reissue got %0d want 1", count); end
  endtask

  task automatic test_random();
    int pend[$];
    int k;
    do_flush();
    for (int c = 0; c < 400; c++) begin
      req_valid = 1'($urandom_range(0, 1)); req_user = 8'($urandom);
      fpu_in_ready = ($urandom_range(0, 3) != 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      pend.delete();
      foreach (q[j]) if (!q[j].done) pend.push_back(j);
      fpu_out_valid = 0;
      if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = pend[$urandom_range(0, pend.size() - 1)];
        fpu_out_valid = 1; fpu_tag_in = 2'(q[k].tag);
        fpu_result = {$urandom, $urandom}; fpu_status = 5'($urandom);
      end
      #1;
      checks++; if (req_ready !== (fpu_in_ready && q.size() < DEPTH && !flush) ||
                    fpu_in_valid !== (req_valid && q.size() < DEPTH && !flush))
        begin errors++; $display("FAIL rnd_hs c=%0d got rdy=%b ivld=%b qsize=%0d", c, req_ready, fpu_in_valid, q.size()); end
      checks++; if (fpu_tag_o !== 2'(next_tag))
        begin errors++; $display("FAIL rnd_tag c=%0d got %0d want %0d", c, fpu_tag_o, next_tag); end
      checks++; if (count !== 3'(q.size()) || busy !== (q.size() != 0) || err !== err_m)
        begin errors++; $display("FAIL rnd_state c=%0d got cnt=%0d busy=%b err=%b want %0d %b", c, count, busy, err, q.size(), err_m); end
      checks++; if (rsp_valid !== (q.size() > 0 && q[0].done))
        begin errors++; $display("FAIL rnd_valid c=%0d got %b", c, rsp_valid); end
      if (q.size() > 0 && q[0].done) begin
        checks++; if (rsp_user !== q[0].user || rsp_result !== q[0].res || rsp_status !== q[0].st)
          begin errors++; $display("FAIL rnd_rsp c=%0d got u=%h r=%h s=%h want %h %h %h", c, rsp_user, rsp_result, rsp_status, q[0].user, q[0].res, q[0].st); end
      end
      step();
    end
    req_valid = 0; rsp_ready = 0; fpu_out_valid = 0; flush = 0;
  endtask

  task automatic test_bogus_and_reset();
    do_flush();
    issue(8'h77);
    ret(2'd2, 64'hBAD, 5'h1F);
    checks++; if (err !== 1'b1 || count !== 3'd1)
      begin errors++; $display("FAIL bogus got err=%b cnt=%0d want 1 1", err, count); end
    ret(2'd0, 64'h5, 5'h0);
    #2; rst = 1; #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || count !== 3'd0 || err !== 1'b0)
      begin errors++; $display("FAIL async_reset got v=%b busy=%b cnt=%0d err=%b want 0 0 0 0", rsp_valid, busy, count, err); end
    q.delete(); next_tag = 0; err_m = 0;
    @(negedge clk); rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_inorder_single();
    test_out_of_order();
    test_full();
    test_backpressure();
    test_flush();
    test_random();
    test_bogus_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
